model: RTL and testbench
========================

MODEL -- requirements
Module: model

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk and resetn; all state changes on the rising edge of clk.
REQ-002 Port: clk  input  1  system clock, rising-edge active.
REQ-003 Port: resetn  input  1  synchronous active-low reset, sampled on the rising clk edge.
REQ-004 Port: din  input  1  serial data bit, meaningful only when cen=1.
REQ-005 Port: cen  input  1  sample enable; 1 = din is a valid sample this cycle.
REQ-006 Port: doutx  output  1  Mealy flag: current valid din equals the previous valid din (run of >=2).
REQ-007 Port: douty  output  1  Mealy flag: current valid din equals the previous two valid dins (run of >=3).
REQ-008 No parameters; all widths fixed at 1.

Function
REQ-009 SHALL be a Mealy FSM with 5 states: IDLE (no history), S0_1 (last valid bit 0, run length 1), S0_2 (last 0, run >=2), S1_1 (last 1, run 1), S1_2 (last 1, run >=2).
REQ-010 Outputs SHALL be combinational from the current state, din, cen and resetn, with zero-cycle latency and no output register.
REQ-011 doutx = resetn & cen & (state != IDLE) & (din == last bit of state).
REQ-012 douty = resetn & cen & (state in {S0_2, S1_2}) & (din == last bit of state).
REQ-013 douty=1 SHALL imply doutx=1.
REQ-014 When cen=0: both outputs 0, state held, din ignored.
REQ-015 Transitions on a clk edge with resetn=1 and cen=1:
REQ-016 - IDLE: din=0 -> S0_1; din=1 -> S1_1.
REQ-017 - Sx_1 with din==x -> Sx_2; with din!=x -> S(din)_1.
REQ-018 - Sx_2 with din==x -> stay in Sx_2 (run length saturates); with din!=x -> S(din)_1.
REQ-019 Runs of any length SHALL keep doutx/douty asserted for every matching valid sample; there is no wrap-around or overflow.
REQ-020 Non-valid (cen=0) cycles SHALL NOT break a run; consecutive valid samples are compared regardless of idle gaps.
REQ-021 Unreachable state encodings SHALL recover to IDLE on the next clock.

Reset
REQ-022 When resetn=0 at a rising clk edge, state SHALL go to IDLE regardless of cen and din; reset has priority over cen.
REQ-023 While resetn=0, doutx and douty SHALL be 0 combinationally.
REQ-024 Reset in the middle of a run SHALL discard all history; the first valid sample after reset SHALL produce doutx=0 and douty=0.
REQ-025 There SHALL be no asynchronous reset path.

Structure
REQ-026 SHALL use a shared package model_pkg holding the state_t enum (IDLE, S0_1, S0_2, S1_1, S1_2) with a 3-bit encoding.
REQ-027 SHALL be a single module with no sub-modules.
REQ-028 SHALL use one sequential process for the state register and one combinational process for next-state and outputs.

Verification
REQ-029 Reset, then 11 cycles with cen=11111111011, din=01111111010, resetn=11111110111 (index 0 first) -> doutx=00111110000, douty=00011110000.
REQ-030 Reset, cen=1, din=000 -> doutx=0,1,1 and douty=0,0,1.
REQ-031 Reset, cen=1,0,0,1,1 with din=1,0,0,1,1 -> doutx=0,0,0,1,1 and douty=0,0,0,0,1; cen=0 cycles show doutx=0 and douty=0, and the idle gap does not break the run.
REQ-032 Reset, cen=1, din=010101 -> doutx=0 and douty=0 on every cycle.
REQ-033 Reset, cen=1, din=1111, then resetn=0 for one cycle, then din=11 -> doutx=0,1,1,1,0,0,1 and douty=0,0,1,1,0,0,0.
REQ-034 Random din, cen and resetn compared against a reference model of REQ-011/REQ-012 -> no mismatches; douty never 1 while doutx is 0.

Source files
------------

// File: rtl/model_pkg.sv
// Shared types for the repeated-bit detector: state encoding and a helper
// that recovers the most recent valid bit from a state.
package model_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    S0_1 = 3'd1,
    S0_2 = 3'd2,
    S1_1 = 3'd3,
    S1_2 = 3'd4
  } state_t;

  function automatic logic last_bit(input state_t s);
    return (s == S1_1) || (s == S1_2);
  endfunction

endpackage

// File: rtl/model_if.sv
// Serial sample bus: valid-qualified input bit plus the two run-detect flags.
interface model_if;
  logic din;
  logic cen;
  logic doutx;
  logic douty;

  modport master (output din, output cen, input doutx, input douty);
  modport slave  (input din, input cen, output doutx, output douty);
endinterface

// File: rtl/model.sv
// Mealy run detector: flags when the current valid bit repeats the previous one (doutx)
// or the previous two (douty); zero-cycle latency, idle (cen=0) cycles hold history.
module model
  import model_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  model_if.slave bus
);

  state_t state_q;
  state_t state_d;
  logic   doutx_d;
  logic   douty_d;
  logic   hit;

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    doutx_d = 1'b0;
    douty_d = 1'b0;
    hit     = resetn & bus.cen & (bus.din == last_bit(state_q));
    case (state_q)
      IDLE: begin
        if (bus.cen) state_d = bus.din ? S1_1 : S0_1;
      end
      S0_1, S0_2: begin
        doutx_d = hit;
        douty_d = hit & (state_q == S0_2);
        if (bus.cen) state_d = bus.din ? S1_1 : S0_2;
      end
      S1_1, S1_2: begin
        doutx_d = hit;
        douty_d = hit & (state_q == S1_2);
        if (bus.cen) state_d = bus.din ? S1_2 : S0_1;
      end
      // Illegal encodings fall back to IDLE on the next edge.
      default: state_d = IDLE;
    endcase
  end

  assign bus.doutx = doutx_d;
  assign bus.douty = douty_d;

endmodule

// File: tb/tb_model.sv
// Directed-vector and randomized checks of the run detector.
module tb_model;

  logic clk;
  logic resetn;
  int   total;
  int   bad;

  model_if bus();

  model dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic c, input logic d, input logic r);
    @(negedge clk);
    bus.cen = c;
    bus.din = d;
    resetn  = r;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0);
    @(posedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0);
    total++;
    if (bus.doutx !== 1'b0 || bus.douty !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs doutx=%0b douty=%0b want 0 0", bus.doutx, bus.douty);
    end
    drive(1'b1, 1'b0, 1'b1);
    total++;
    if (bus.doutx !== 1'b0 || bus.douty !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_sample doutx=%0b douty=%0b want 0 0", bus.doutx, bus.douty);
    end
    drive(1'b1, 1'b0, 1'b1);
    total++;
    if (bus.doutx !== 1'b1 || bus.douty !== 1'b0) begin
      bad++;
      $display("FAIL reset_second_sample doutx=%0b douty=%0b want 1 0", bus.doutx, bus.douty);
    end
  endtask

  task automatic test_mixed();
    logic [10:0] cv = 11'b11111111011;
    logic [10:0] dv = 11'b01111111010;
    logic [10:0] rv = 11'b11111110111;
    logic [10:0] xv = 11'b00111110000;
    logic [10:0] yv = 11'b00011110000;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      drive(cv[10-i], dv[10-i], rv[10-i]);
      total++;
      if (bus.doutx !== xv[10-i] || bus.douty !== yv[10-i]) begin
        bad++;
        $display("FAIL mixed[%0d] doutx=%0b douty=%0b want %0b %0b",
                 i, bus.doutx, bus.douty, xv[10-i], yv[10-i]);
      end
    end
  endtask

  task automatic test_zeros();
    logic [2:0] xv = 3'b011;
    logic [2:0] yv = 3'b001;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1);
      total++;
      if (bus.doutx !== xv[2-i] || bus.douty !== yv[2-i]) begin
        bad++;
        $display("FAIL zeros[%0d] doutx=%0b douty=%0b want %0b %0b",
                 i, bus.doutx, bus.douty, xv[2-i], yv[2-i]);
      end
    end
  endtask

  task automatic test_gap();
    logic [4:0] cv = 5'b10011;
    logic [4:0] dv = 5'b10011;
    logic [4:0] xv = 5'b00011;
    logic [4:0] yv = 5'b00001;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(cv[4-i], dv[4-i], 1'b1);
      total++;
      if (bus.doutx !== xv[4-i] || bus.douty !== yv[4-i]) begin
        bad++;
        $display("FAIL gap[%0d] doutx=%0b douty=%0b want %0b %0b",
                 i, bus.doutx, bus.douty, xv[4-i], yv[4-i]);
      end
    end
  endtask

  task automatic test_alternate();
    logic [5:0] dv = 6'b010101;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, dv[5-i], 1'b1);
      total++;
      if (bus.doutx !== 1'b0 || bus.douty !== 1'b0) begin
        bad++;
        $display("FAIL alternate[%0d] doutx=%0b douty=%0b want 0 0", i, bus.doutx, bus.douty);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [6:0] rv = 7'b1111011;
    logic [6:0] xv = 7'b0111001;
    logic [6:0] yv = 7'b0011000;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b1, rv[6-i]);
      total++;
      if (bus.doutx !== xv[6-i] || bus.douty !== yv[6-i]) begin
        bad++;
        $display("FAIL mid_reset[%0d] doutx=%0b douty=%0b want %0b %0b",
                 i, bus.doutx, bus.douty, xv[6-i], yv[6-i]);
      end
    end
  endtask

  task automatic test_random();
    logic c, d, r, ex, ey, last;
    int   run;
    do_reset();
    run  = 0;
    last = 1'b0;
    for (int i = 0; i < 400; i++) begin
      c = 1'($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 2) != 0);
      r = 1'($urandom_range(0, 24) != 0);
      drive(c, d, r);
      ex = r && c && run >= 1 && d == last;
      ey = r && c && run >= 2 && d == last;
      total++;
      if (bus.doutx !== ex || bus.douty !== ey) begin
        bad++;
        $display("FAIL random[%0d] doutx=%0b douty=%0b want %0b %0b",
                 i, bus.doutx, bus.douty, ex, ey);
      end
      total++;
      if (bus.douty === 1'b1 && bus.doutx !== 1'b1) begin
        bad++;
        $display("FAIL implication[%0d] doutx=%0b douty=%0b want doutx 1", i, bus.doutx, bus.douty);
      end
      if (!r) begin
        run = 0;
      end else if (c) begin
        if (run == 0 || d != last) run = 1;
        else if (run < 2) run = run + 1;
        last = d;
      end
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    bus.cen = 1'b0;
    bus.din = 1'b0;
    resetn  = 1'b0;
    test_reset();
    test_mixed();
    test_zeros();
    test_gap();
    test_alternate();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
